muldiv_sequencer: RTL

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_if.sv | 26 ++
 rtl/muldiv_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Purpose : handshake/data bundle between a pipeline stage and muldiv_sequencer.
// Ports   : start/func3/op_a/op_b/flush are requests; busy/stall/done/result are status and result.
// Modports: master = requester (pipeline or bench), slave = sequencer.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, op_a, op_b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, func3, op_a, op_b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Purpose : iterative RV32M multiply/divide unit, one radix-2 step per cycle on operand magnitudes.
// Latency : done XLEN+1 edges after the start-sampling edge (1 edge for divide-by-zero/overflow).
// Backpressure: none accepted; the unit requests a pipeline stall while busy computing.
// Ports   : clk, rst (sync, active-high); bus (slave modport): start, func3, op_a, op_b, flush in;
//           busy, stall, done, result out.
// Config  : define MULDIV_DIV_EN to build the divider; otherwise func3[2]=1 ops return 0 immediately.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_sequencer_if.slave   bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;         // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;         // multiplier / dividend, shifted out as quotient shifts in
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q, neg_d;       // product or quotient must be negated
  logic            low_q, low_d;       // MUL: return low half of product
`ifdef MULDIV_DIV_EN
  logic            div_q, div_d;
  logic            rem_q, rem_d;
  logic            rneg_q, rneg_d;     // remainder takes dividend sign
`endif

  // Operand decode
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            accept, last_iter, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (bus.func3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    a_neg = a_signed & bus.op_a[XLEN-1];
    b_neg = b_signed & bus.op_b[XLEN-1];
    a_mag = a_neg ? -bus.op_a : bus.op_a;
    b_mag = b_neg ? -bus.op_b : bus.op_b;
  end

  assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush;
  assign last_iter = (state_q == S_CALC) && (cnt_q == CW'(XLEN - 1));

  // Divide-by-zero and signed overflow bypass the iteration entirely.
`ifdef MULDIV_DIV_EN
  logic div_zero, div_ovf;
  always_comb begin
    div_zero = (bus.op_b == '0);
    div_ovf  = !bus.func3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    fast     = bus.func3[2] && (div_zero || div_ovf);
    if (bus.func3[1]) fast_res = div_zero ? bus.op_a : '0;
    else              fast_res = div_zero ? '1 : bus.op_a;
  end
`else
  assign fast     = bus.func3[2];
  assign fast_res = '0;
`endif

  // One iteration step
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   calc_res;

  always_comb begin
    mul_sum = {1'b0, hi_q} + ({1'b0, opnd_q} & {(XLEN+1){lo_q[0]}});
    hi_nx   = mul_sum[XLEN:1];
    lo_nx   = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    if (div_q) begin : div_step
      logic [XLEN:0] shifted, diff;
      shifted = {hi_q, lo_q[XLEN-1]};
      diff    = shifted - {1'b0, opnd_q};
      // Restoring: keep the difference only when it did not borrow.
      hi_nx   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_nx   = {lo_q[XLEN-2:0], !diff[XLEN]};
    end
`endif
  end

  // Sign fix-up on the values produced by the final iteration.
  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    calc_res = low_q ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    if (div_q) begin
      if (rem_q) calc_res = rneg_q ? -hi_nx : hi_nx;
      else       calc_res = neg_q  ? -lo_nx : lo_nx;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      low_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      low_q    <= low_d;
`ifdef MULDIV_DIV_EN
      div_q    <= div_d;
      rem_q    <= rem_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = fast ? S_DONE : S_CALC;
      S_CALC:  if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    neg_d    = neg_q;
    low_d    = low_q;
`ifdef MULDIV_DIV_EN
    div_d    = div_q;
    rem_d    = rem_q;
    rneg_d   = rneg_q;
`endif
    if (accept) begin
      cnt_d  = '0;
      hi_d   = '0;
      neg_d  = a_neg ^ b_neg;
      low_d  = (bus.func3 == 3'b000);
      opnd_d = a_mag;
      lo_d   = b_mag;
`ifdef MULDIV_DIV_EN
      div_d  = bus.func3[2];
      rem_d  = bus.func3[1];
      rneg_d = a_neg;
      if (bus.func3[2]) begin
        opnd_d = b_mag;
        lo_d   = a_mag;
      end
`endif
      if (fast) result_d = fast_res;
    end else if ((state_q == S_CALC) && !bus.flush) begin
      cnt_d = cnt_q + CW'(1);
      hi_d  = hi_nx;
      lo_d  = lo_nx;
      if (last_iter) result_d = calc_res;
    end
  end

  // Outputs
  always_comb begin
    bus.busy   = (state_q != S_IDLE);
    bus.done   = (state_q == S_DONE);
    bus.stall  = !rst && ((accept) || (state_q == S_CALC));
    bus.result = result_q;
  end

endmodule
